// File: rtl/exception_unit.sv
// rtl/exception_unit.sv - exception/interrupt controller: EPC/Cause, flush and handler redirect
module exception_unit #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
    parameter int          DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ovf_ex,
    input  logic        und_id,
    input  logic        eret_id,
    input  logic        irq,
    input  logic        id_valid,
    input  logic        br_flush,
    input  logic [31:0] pc_id,
    input  logic [31:0] pc_ex,
    output logic        flush_if,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] EPC,
    output logic [31:0] cause,
    output logic        exception,
    output logic        exl
);

    localparam logic [2:0] S_RUN     = 3'd0;
    localparam logic [2:0] S_TAKE    = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_HANDLER = 3'd3;
    localparam logic [2:0] S_RET     = 3'd4;

    localparam logic [4:0] EXC_OVF = 5'd12;
    localparam logic [4:0] EXC_UND = 5'd10;
    localparam logic [4:0] EXC_INT = 5'd0;

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    logic [2:0]       state;
    logic [4:0]       exc_code;
    logic             take_ovf;
    logic [CNT_W-1:0] drain_cnt;

    logic        id_ok;
    logic        ev_und;
    logic        ev_irq;
    logic        ev_eret;
    logic        sampling;
    logic        take_ev;
    logic [4:0]  take_code;
    logic [31:0] take_pc;

    // ID-side events only count for a real instruction that is not being squashed by a branch;
    // exl masks interrupts so irq can never nest inside the handler
    assign id_ok    = id_valid & ~br_flush;
    assign ev_und   = und_id & id_ok;
    assign ev_irq   = irq & id_ok & ~exl;
    assign ev_eret  = eret_id & id_ok;
    assign sampling = (state == S_RUN) || (state == S_HANDLER);

    // Fixed-priority selection of the event to take: overflow, then undefined, then interrupt
    always_comb begin
        take_ev   = sampling & (ovf_ex | ev_und | ev_irq);
        take_code = EXC_INT;
        take_pc   = pc_id;
        if (ovf_ex) begin
            take_code = EXC_OVF;
            take_pc   = pc_ex;
        end else if (ev_und) begin
            take_code = EXC_UND;
        end
    end

    // Controller state, EPC/Cause/EXL registers and the drain down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            exc_code  <= 5'd0;
            EPC       <= 32'd0;
            exl       <= 1'b0;
            take_ovf  <= 1'b0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_RUN, S_HANDLER: begin
                    if (take_ev) begin
                        state    <= S_TAKE;
                        exc_code <= take_code;
                        // a nested exception must keep the return address of the outer one
                        if (!exl) begin
                            EPC <= take_pc;
                        end
                        exl      <= 1'b1;
                        take_ovf <= ovf_ex;
                    end else if ((state == S_HANDLER) && ev_eret) begin
                        state <= S_RET;
                    end
                end
                S_TAKE: begin
                    take_ovf <= 1'b0;
                    if (DRAIN_CYCLES > 1) begin
                        state     <= S_DRAIN;
                        drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
                    end else begin
                        state <= S_HANDLER;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt <= CNT_W'(1)) begin
                        state     <= S_HANDLER;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                S_RET: begin
                    exl   <= 1'b0;
                    state <= S_RUN;
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

    // Outputs decode from state and registers only, so no input reaches an output combinationally
    always_comb begin
        exception   = (state == S_TAKE);
        pc_redirect = (state == S_TAKE) || (state == S_RET);
        flush_if    = (state == S_TAKE) || (state == S_DRAIN) || (state == S_RET);
        flush_id    = flush_if;
        flush_ex    = (state == S_TAKE) && take_ovf;
        if (state == S_TAKE) begin
            redirect_pc = HANDLER_ADDR;
        end else if (state == S_RET) begin
            redirect_pc = EPC;
        end else begin
            redirect_pc = 32'd0;
        end
        cause = {25'd0, exc_code, 2'b00};
    end

endmodule

// File: tb/tb_exception_unit.sv
// tb/tb_exception_unit.sv - directed table-driven bench for exception_unit
module tb_exception_unit;

    logic        clk;
    logic        rst_n;
    logic        ovf_ex, und_id, eret_id, irq, id_valid, br_flush;
    logic [31:0] pc_id, pc_ex;

    logic        flush_if, flush_id, flush_ex, pc_redirect, exception, exl;
    logic [31:0] redirect_pc, EPC, cause;

    logic        d1_flush_if, d1_flush_id, d1_flush_ex, d1_pc_redirect, d1_exception, d1_exl;
    logic [31:0] d1_redirect_pc, d1_epc, d1_cause;

    int n_checks = 0;
    int n_errors = 0;

    exception_unit #(.HANDLER_ADDR(32'h0000_0080), .DRAIN_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .ovf_ex(ovf_ex), .und_id(und_id), .eret_id(eret_id),
        .irq(irq), .id_valid(id_valid), .br_flush(br_flush), .pc_id(pc_id), .pc_ex(pc_ex),
        .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
        .pc_redirect(pc_redirect), .redirect_pc(redirect_pc), .EPC(EPC), .cause(cause),
        .exception(exception), .exl(exl)
    );

    exception_unit #(.HANDLER_ADDR(32'h0000_0080), .DRAIN_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ovf_ex(ovf_ex), .und_id(und_id), .eret_id(eret_id),
        .irq(irq), .id_valid(id_valid), .br_flush(br_flush), .pc_id(pc_id), .pc_ex(pc_ex),
        .flush_if(d1_flush_if), .flush_id(d1_flush_id), .flush_ex(d1_flush_ex),
        .pc_redirect(d1_pc_redirect), .redirect_pc(d1_redirect_pc), .EPC(d1_epc),
        .cause(d1_cause), .exception(d1_exception), .exl(d1_exl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  in_bits;   // {ovf, und, eret, irq, id_valid, br_flush}
        logic [31:0] pid;
        logic [31:0] pex;
        logic [3:0]  fl;        // {flush_if, flush_id, flush_ex, pc_redirect}
        logic [31:0] rpc;
        logic [31:0] epc;
        logic [31:0] cause;
        logic        exc;
        logic        exl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [5:0] in_bits, input logic [31:0] pid,
                                input logic [31:0] pex, input logic [3:0] fl,
                                input logic [31:0] rpc, input logic [31:0] epc,
                                input logic [31:0] cs, input logic exc, input logic xl);
        vec_t v;
        v.in_bits = in_bits; v.pid = pid; v.pex = pex; v.fl = fl; v.rpc = rpc;
        v.epc = epc; v.cause = cs; v.exc = exc; v.exl = xl;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] b, input logic [31:0] pid, input logic [31:0] pex);
        {ovf_ex, und_id, eret_id, irq, id_valid, br_flush} = b;
        pc_id = pid;
        pc_ex = pex;
    endtask

    function automatic logic [127:0] dut_all();
        return {26'd0, flush_if, flush_id, flush_ex, pc_redirect, exception, exl,
                redirect_pc, EPC, cause};
    endfunction

    function automatic logic [127:0] dut1_all();
        return {26'd0, d1_flush_if, d1_flush_id, d1_flush_ex, d1_pc_redirect, d1_exception,
                d1_exl, d1_redirect_pc, d1_epc, d1_cause};
    endfunction

    localparam logic [5:0] IDLE = 6'b000010;

    initial begin
        int cnt0;
        int cnt1;

        // inputs {ovf,und,eret,irq,idv,brf}; expected {if,id,ex,red}, rpc, epc, cause, exc, exl
        vecs.push_back(mk(6'b100010, 32'h44,  32'h40,  4'b1111, 32'h80,  32'h40,  32'h30, 1, 1));
        vecs.push_back(mk(IDLE,      32'h0,   32'h0,   4'b1100, 32'h0,   32'h40,  32'h30, 0, 1));
        vecs.push_back(mk(IDLE,      32'h0,   32'h0,   4'b0000, 32'h0,   32'h40,  32'h30, 0, 1));
        vecs.push_back(mk(6'b001010, 32'h48,  32'h0,   4'b1101, 32'h40,  32'h40,  32'h30, 0, 1));
        vecs.push_back(mk(IDLE,      32'h0,   32'h0,   4'b0000, 32'h0,   32'h40,  32'h30, 0, 0));
        vecs.push_back(mk(6'b010010, 32'h100, 32'h0,   4'b1101, 32'h80,  32'h100, 32'h28, 1, 1));
        vecs.push_back(mk(IDLE,      32'h0,   32'h0,   4'b1100, 32'h0,   32'h100, 32'h28, 0, 1));
        vecs.push_back(mk(IDLE,      32'h0,   32'h0,   4'b0000, 32'h0,   32'h100, 32'h28, 0, 1));
        vecs.push_back(mk(6'b001010, 32'h0,   32'h0,   4'b1101, 32'h100, 32'h100, 32'h28, 0, 1));
        vecs.push_back(mk(IDLE,      32'h0,   32'h0,   4'b0000, 32'h0,   32'h100, 32'h28, 0, 0));
        vecs.push_back(mk(6'b010011, 32'h104, 32'h0,   4'b0000, 32'h0,   32'h100, 32'h28, 0, 0));
        vecs.push_back(mk(6'b001010, 32'h108, 32'h0,   4'b0000, 32'h0,   32'h100, 32'h28, 0, 0));
        vecs.push_back(mk(6'b010000, 32'h10c, 32'h0,   4'b0000, 32'h0,   32'h100, 32'h28, 0, 0));
        vecs.push_back(mk(6'b000110, 32'h200, 32'h0,   4'b1101, 32'h80,  32'h200, 32'h0,  1, 1));
        vecs.push_back(mk(6'b000110, 32'h200, 32'h0,   4'b1100, 32'h0,   32'h200, 32'h0,  0, 1));
        vecs.push_back(mk(6'b000110, 32'h200, 32'h0,   4'b0000, 32'h0,   32'h200, 32'h0,  0, 1));
        vecs.push_back(mk(6'b001110, 32'h300, 32'h0,   4'b1101, 32'h200, 32'h200, 32'h0,  0, 1));
        vecs.push_back(mk(6'b000110, 32'h204, 32'h0,   4'b0000, 32'h0,   32'h200, 32'h0,  0, 0));
        vecs.push_back(mk(6'b000110, 32'h208, 32'h0,   4'b1101, 32'h80,  32'h208, 32'h0,  1, 1));
        vecs.push_back(mk(IDLE,      32'h0,   32'h0,   4'b1100, 32'h0,   32'h208, 32'h0,  0, 1));
        vecs.push_back(mk(IDLE,      32'h0,   32'h0,   4'b0000, 32'h0,   32'h208, 32'h0,  0, 1));
        vecs.push_back(mk(6'b001010, 32'h0,   32'h0,   4'b1101, 32'h208, 32'h208, 32'h0,  0, 1));
        vecs.push_back(mk(IDLE,      32'h0,   32'h0,   4'b0000, 32'h0,   32'h208, 32'h0,  0, 0));
        vecs.push_back(mk(6'b110110, 32'h504, 32'h500, 4'b1111, 32'h80,  32'h500, 32'h30, 1, 1));
        vecs.push_back(mk(6'b100010, 32'h0,   32'h510, 4'b1100, 32'h0,   32'h500, 32'h30, 0, 1));
        vecs.push_back(mk(6'b100010, 32'h0,   32'h520, 4'b0000, 32'h0,   32'h500, 32'h30, 0, 1));
        vecs.push_back(mk(6'b000110, 32'h600, 32'h0,   4'b0000, 32'h0,   32'h500, 32'h30, 0, 1));
        vecs.push_back(mk(6'b010010, 32'h84,  32'h0,   4'b1101, 32'h80,  32'h500, 32'h28, 1, 1));
        vecs.push_back(mk(IDLE,      32'h0,   32'h0,   4'b1100, 32'h0,   32'h500, 32'h28, 0, 1));
        vecs.push_back(mk(IDLE,      32'h0,   32'h0,   4'b0000, 32'h0,   32'h500, 32'h28, 0, 1));
        vecs.push_back(mk(6'b001011, 32'h0,   32'h0,   4'b0000, 32'h0,   32'h500, 32'h28, 0, 1));
        vecs.push_back(mk(6'b001010, 32'h0,   32'h0,   4'b1101, 32'h500, 32'h500, 32'h28, 0, 1));
        vecs.push_back(mk(IDLE,      32'h0,   32'h0,   4'b0000, 32'h0,   32'h500, 32'h28, 0, 0));

        rst_n = 1'b0;
        drive(6'b000000, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_d2", dut_all(), 128'd0);
        check("reset_d1", dut1_all(), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].in_bits, vecs[i].pid, vecs[i].pex);
            @(posedge clk);
            #1;
            check($sformatf("v%0d.flush_if", i),  128'(flush_if),    128'(vecs[i].fl[3]));
            check($sformatf("v%0d.flush_id", i),  128'(flush_id),    128'(vecs[i].fl[2]));
            check($sformatf("v%0d.flush_ex", i),  128'(flush_ex),    128'(vecs[i].fl[1]));
            check($sformatf("v%0d.redirect", i),  128'(pc_redirect), 128'(vecs[i].fl[0]));
            check($sformatf("v%0d.rpc", i),       128'(redirect_pc), 128'(vecs[i].rpc));
            check($sformatf("v%0d.epc", i),       128'(EPC),         128'(vecs[i].epc));
            check($sformatf("v%0d.cause", i),     128'(cause),       128'(vecs[i].cause));
            check($sformatf("v%0d.exception", i), 128'(exception),   128'(vecs[i].exc));
            check($sformatf("v%0d.exl", i),       128'(exl),         128'(vecs[i].exl));
        end

        // asynchronous reset while the DRAIN_CYCLES=2 unit sits in DRAIN
        @(negedge clk);
        drive(6'b100010, 32'h14, 32'h10);
        @(posedge clk);
        #1;
        check("pre_rst_take", 128'(exception), 128'(1));
        @(negedge clk);
        drive(IDLE, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("pre_rst_drain", 128'({flush_if, exception}), 128'(2'b10));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_drain_rst_d2", dut_all(), 128'd0);
        check("mid_drain_rst_d1", dut1_all(), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // after release both builds accept an overflow; count IF flush cycles per build
        @(negedge clk);
        drive(6'b100010, 32'h704, 32'h700);
        @(posedge clk);
        #1;
        check("post_rst_exc_d2", 128'({exception, flush_ex, EPC, cause}),
              128'({1'b1, 1'b1, 32'h700, 32'h30}));
        check("post_rst_exc_d1", 128'({d1_exception, d1_flush_ex, d1_epc, d1_cause}),
              128'({1'b1, 1'b1, 32'h700, 32'h30}));
        cnt0 = int'(flush_if);
        cnt1 = int'(d1_flush_if);
        @(negedge clk);
        drive(IDLE, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("d1_direct_handler", 128'({d1_flush_if, d1_exception, d1_pc_redirect, d1_exl}),
              128'(4'b0001));
        for (int k = 0; k < 4; k++) begin
            cnt0 += int'(flush_if);
            cnt1 += int'(d1_flush_if);
            @(posedge clk);
            #1;
        end
        check("flush_len_d2", 128'(cnt0), 128'(2));
        check("flush_len_d1", 128'(cnt1), 128'(1));
        check("handler_exl", 128'({exl, d1_exl}), 128'(2'b11));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/exception_unit.md
# exception_unit

Sequential exception/interrupt controller for the 5-stage MIPS pipeline; it supplies the real `EPC`, `cause` and `exception` values that the decode controller currently ties to zero. It prioritises three event sources: ALU overflow in EX, undefined instruction in ID and the external interrupt. For each accepted event it latches EPC and Cause, issues per-stage flushes and a PC redirect to the handler, and tracks handler residency (EXL). On ERET it returns to EPC.

## Interface
Parameters:
- `HANDLER_ADDR`, 32'h0000_0080, PC redirect target for every exception.
- `DRAIN_CYCLES`, 2, total cycles IF/ID flush is held after an exception is taken (min 1).

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ovf_ex` input 1: signed overflow of the instruction in EX.
- `und_id` input 1: instruction in ID is undefined.
- `eret_id` input 1: instruction in ID is ERET.
- `irq` input 1: external interrupt, level-sensitive.
- `id_valid` input 1: ID holds a real (non-bubble) instruction.
- `br_flush` input 1: branch/jump redirect squashing IF/ID this cycle.
- `pc_id` input 32: PC of the ID instruction.
- `pc_ex` input 32: PC of the EX instruction.
- `flush_if`, `flush_id`, `flush_ex` output 1 each: per-stage squash.
- `pc_redirect` output 1: PC mux selects `redirect_pc`.
- `redirect_pc` output 32: redirect target.
- `EPC` output 32: exception PC register.
- `cause` output 32: Cause register; ExcCode in [6:2], all other bits 0.
- `exception` output 1: one-cycle pulse when an exception is taken.
- `exl` output 1: handler in progress.

## Operation
- FSM states: RUN, TAKE, DRAIN, HANDLER, RET.
- Events sampled in RUN and HANDLER. Fixed priority: ovf (ExcCode 12) > und (10) > irq (0).
  - `ovf_ex` qualifies unconditionally.
  - `und_id` and `eret_id` require `id_valid & ~br_flush`.
  - `irq` requires `id_valid & ~br_flush & ~exl`.
- Accepted event at edge T (RUN → TAKE, or HANDLER → TAKE for a synchronous event):
  - `cause[6:2]` is loaded with the ExcCode.
  - `EPC` is loaded with `pc_ex` (ovf) or `pc_id` (und/irq), but only if `exl` was 0. A nested synchronous exception keeps the old EPC.
  - `exl` is set to 1.
- TAKE (1 cycle):
  - `exception` = 1, `pc_redirect` = 1, `redirect_pc` = HANDLER_ADDR.
  - `flush_if` = `flush_id` = 1.
  - `flush_ex` = 1 only for ovf, so the overflowing result is not written.
  - Next state: DRAIN if DRAIN_CYCLES > 1, else HANDLER.
- DRAIN: `flush_if` and `flush_id` held for DRAIN_CYCLES−1 cycles using a down-counter; then HANDLER.
- HANDLER: outputs idle and `exl` = 1. Qualified `eret_id` with no higher event moves to RET.
- RET (1 cycle):
  - `pc_redirect` = 1, `redirect_pc` = EPC, `flush_if` = `flush_id` = 1.
  - `exl` is cleared at the end of the cycle; next state RUN.
- `eret_id` in RUN is ignored, with no redirect.
- Events arriving in TAKE, DRAIN or RET are ignored and not queued. `irq` is level-sensitive, so a still-asserted irq is taken later.
- Cause keeps the last ExcCode until the next exception.

## Timing
- All outputs are registered or decoded from the FSM state only; there is no combinational path from inputs to outputs.
- Latency is 1 cycle: an event in cycle T gives `exception`/`pc_redirect` high in cycle T+1.
- Handler fetch begins at T+2. IF/ID flush spans cycles T+1 .. T+DRAIN_CYCLES.
- ERET seen in ID at cycle R gives redirect to EPC in R+1; `exl` = 0 from R+2.
- Reset (`rst_n` low, at any time including mid-TAKE/DRAIN/RET) immediately forces:
  - state RUN, EPC = 0, cause = 0, exl = 0;
  - all flush/redirect/exception outputs 0, `redirect_pc` = 0, drain counter = 0.
- Simultaneous `ovf_ex` and `und_id` in the same cycle: ovf wins, EPC = `pc_ex`, and the ID instruction is flushed.

## Test plan
- Overflow: `ovf_ex`=1 with `pc_ex`=0x40, `pc_id`=0x44 → next cycle `exception`=1, `redirect_pc`=0x80, `flush_ex`=1; EPC=0x40, cause=0x30, exl=1; IF/ID flush lasts 2 cycles.
- Undefined instruction: `und_id`=1, `id_valid`=1, `pc_id`=0x100 → EPC=0x100, cause=0x28, `flush_ex`=0. Repeat with `br_flush`=1 → nothing is taken.
- Interrupt plus return: `irq`=1 at `pc_id`=0x200 → EPC=0x200, cause=0. Hold `irq`, then `eret_id` in HANDLER → `redirect_pc`=0x200 one cycle, exl=0. Since irq is still high, it is retaken once RUN is reached.
- Priority and nesting: ovf+und+irq in the same cycle → cause=0x30. Then in HANDLER, `und_id` with `pc_id`=0x84 → cause=0x28, EPC unchanged at its earlier value. `irq` in HANDLER is ignored.
- Reset mid-DRAIN: drop `rst_n` during DRAIN → all outputs 0 asynchronously; after release, state is RUN and a new `ovf_ex` is accepted normally.
- DRAIN_CYCLES=1 build: the exception goes TAKE → HANDLER directly, with flush asserted for exactly 1 cycle.
